// File: rtl/bridge_pkg.sv
// Shared constants for the CPU data-bus bridge: peripheral page decode,
// register offsets and the active-low seven-segment glyph table.
package bridge_pkg;

  localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;
  localparam int unsigned NUM_DIGITS  = 8;
  localparam int unsigned DIG_IDX_W   = 3;

  // Byte offsets inside the peripheral page
  localparam logic [11:0] OFF_DISP  = 12'h000;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  localparam logic [7:0] SEG_RESET = 8'hC0;
  localparam logic [7:0] DIG_RESET = 8'hFE;

  // Hex glyph, segments {dp,g,f,e,d,c,b,a}, active-low, dp off
  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bus_bridge_seg_scan.sv
// Seven-segment scanner: prescaled digit index with registered enable/glyph.
// display is the value the display register holds after this edge.
module seg_scan
  import bridge_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] display,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRE_W-1:0]     pre_q;
  logic [DIG_IDX_W-1:0] idx_q;
  logic [DIG_IDX_W-1:0] idx_d;
  logic                 pre_tc;

  assign pre_tc = (pre_q == PRE_W'(SCAN_DIV - 1));
  assign idx_d  = pre_tc ? idx_q + DIG_IDX_W'(1) : idx_q;

  // Outputs are registered from next-state values so they track idx/display with no lag
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pre_q  <= '0;
      idx_q  <= '0;
      dig_en <= DIG_RESET;
      seg    <= SEG_RESET;
    end else begin
      pre_q  <= pre_tc ? '0 : pre_q + PRE_W'(1);
      idx_q  <= idx_d;
      dig_en <= ~(8'b1 << idx_d);
      seg    <= hex_seg(display[{idx_d, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/bus_bridge.sv
// Data-bus responder: RAM/peripheral decode, combinational read mux, LED,
// display, synchronised switches/buttons. Optional timer under BRIDGE_TIMER_EN.
module bus_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 20000,
  parameter int unsigned TIMER_DIV = 50000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  output logic [31:0] Bus_rdata,
  input  logic        Bus_wen,
  input  logic [31:0] Bus_wdata,
  output logic [13:0] dram_addr,
  input  logic [31:0] dram_rdata,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  logic        periph_hit;
  logic [9:0]  word_off;
  logic        wr_disp;
  logic        wr_led;
  logic [31:0] display_q;
  logic [31:0] display_d;
  logic [23:0] sw_meta, sw_sync;
  logic [4:0]  btn_meta, btn_sync;
  logic        unused_addr_bits;

  assign periph_hit       = (Bus_addr[31:12] == PERIPH_BASE);
  assign word_off         = Bus_addr[11:2];
  assign unused_addr_bits = ^Bus_addr[1:0];

  assign dram_addr  = Bus_addr[15:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen & ~periph_hit;

  assign wr_disp   = Bus_wen & periph_hit & (word_off == OFF_DISP[11:2]);
  assign wr_led    = Bus_wen & periph_hit & (word_off == OFF_LED[11:2]);
  assign display_d = wr_disp ? Bus_wdata : display_q;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      display_q <= '0;
      led       <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      btn_meta  <= '0;
      btn_sync  <= '0;
    end else begin
      display_q <= display_d;
      if (wr_led) led <= Bus_wdata[23:0];
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      btn_meta  <= btn;
      btn_sync  <= btn_meta;
    end
  end

`ifdef BRIDGE_TIMER_EN
  localparam int unsigned TPRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [TPRE_W-1:0] tpre_q;
  logic [31:0]       timer_q;
  logic              wr_timer;
  logic              tpre_tc;

  assign wr_timer = Bus_wen & periph_hit & (word_off == OFF_TIMER[11:2]);
  assign tpre_tc  = (tpre_q == TPRE_W'(TIMER_DIV - 1));

  // A bus write reloads the count and restarts the prescaler, beating any tick
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      tpre_q  <= '0;
      timer_q <= '0;
    end else if (wr_timer) begin
      tpre_q  <= '0;
      timer_q <= Bus_wdata;
    end else if (tpre_tc) begin
      tpre_q  <= '0;
      timer_q <= timer_q + 32'd1;
    end else begin
      tpre_q  <= tpre_q + TPRE_W'(1);
    end
  end
`endif

  always_comb begin
    Bus_rdata = '0;
    if (!periph_hit) begin
      Bus_rdata = dram_rdata;
    end else begin
      case (word_off)
        OFF_DISP[11:2]:  Bus_rdata = display_q;
`ifdef BRIDGE_TIMER_EN
        OFF_TIMER[11:2]: Bus_rdata = timer_q;
`endif
        OFF_LED[11:2]:   Bus_rdata = {8'h00, led};
        OFF_SW[11:2]:    Bus_rdata = {8'h00, sw_sync};
        OFF_BTN[11:2]:   Bus_rdata = {27'h0, btn_sync};
        default:         Bus_rdata = '0;
      endcase
    end
  end

  seg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_seg_scan (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .display(display_d),
    .dig_en (dig_en),
    .seg    (seg)
  );

endmodule

// File: tb/tb_bus_bridge.sv
// Directed bench for bus_bridge with SCAN_DIV=4, TIMER_DIV=3.
module tb_bus_bridge;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] Bus_addr;
  logic [31:0] Bus_rdata;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [13:0] dram_addr;
  logic [31:0] dram_rdata;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int total = 0;
  int bad   = 0;

  // Expected glyphs for digits 0..7 of display 0x76543210
  logic [7:0] glyph [0:7];

  bus_bridge #(
    .SCAN_DIV (4),
    .TIMER_DIV(3)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .Bus_addr  (Bus_addr),
    .Bus_rdata (Bus_rdata),
    .Bus_wen   (Bus_wen),
    .Bus_wdata (Bus_wdata),
    .dram_addr (dram_addr),
    .dram_rdata(dram_rdata),
    .dram_wen  (dram_wen),
    .dram_wdata(dram_wdata),
    .sw        (sw),
    .btn       (btn),
    .led       (led),
    .dig_en    (dig_en),
    .seg       (seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_en;
    glyph[0] = 8'hC0; glyph[1] = 8'hF9; glyph[2] = 8'hA4; glyph[3] = 8'hB0;
    glyph[4] = 8'h99; glyph[5] = 8'h92; glyph[6] = 8'h82; glyph[7] = 8'hF8;

    // Reset with a concurrent LED write that must be suppressed
    cpu_rst    = 1'b1;
    Bus_wen    = 1'b1;
    Bus_addr   = 32'hFFFFF060;
    Bus_wdata  = 32'h00FFFFFF;
    dram_rdata = 32'hCAFEF00D;
    sw         = '0;
    btn        = '0;
    tick();
    cpu_rst = 1'b0;
    Bus_wen = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_dig_en", 32'(dig_en), 32'hFE);
    check("rst_seg", 32'(seg), 32'hC0);
    check("rst_led_read", Bus_rdata, 32'h0);

    // LED write, no RAM strobe
    Bus_wen   = 1'b1;
    Bus_wdata = 32'h00ABCDEF;
    #1;
    check("led_wr_no_dram_wen", 32'(dram_wen), 32'h0);
    tick();
    Bus_wen = 1'b0;
    #1;
    check("led_value", 32'(led), 32'h00ABCDEF);
    check("led_read", Bus_rdata, 32'h00ABCDEF);

    // Upper LED bits are not stored and read back 0
    Bus_wen   = 1'b1;
    Bus_wdata = 32'hFFFFFFFF;
    tick();
    Bus_wen = 1'b0;
    #1;
    check("led_upper_zero", Bus_rdata, 32'h00FFFFFF);

    // RAM write and read
    Bus_addr  = 32'h00000040;
    Bus_wdata = 32'h12345678;
    Bus_wen   = 1'b1;
    #1;
    check("ram_wen", 32'(dram_wen), 32'h1);
    check("ram_addr", 32'(dram_addr), 32'h010);
    check("ram_wdata", dram_wdata, 32'h12345678);
    tick();
    Bus_wen = 1'b0;
    #1;
    check("ram_wen_low", 32'(dram_wen), 32'h0);
    check("ram_read", Bus_rdata, 32'hCAFEF00D);

    // Unmapped peripheral offset reads 0 even with RAM data present
    Bus_addr = 32'hFFFFF0FC;
    #1;
    check("unmapped_read", Bus_rdata, 32'h0);

    // Switch synchroniser: two-cycle latency
    Bus_addr = 32'hFFFFF070;
    sw       = 24'h00F00F;
    #1;
    check("sw_cycle0", Bus_rdata, 32'h0);
    tick();
    check("sw_cycle1", Bus_rdata, 32'h0);
    tick();
    check("sw_cycle2", Bus_rdata, 32'h0000F00F);

    // Write to read-only switch register is ignored
    Bus_wen   = 1'b1;
    Bus_wdata = 32'h00000000;
    #1;
    check("ro_no_dram_wen", 32'(dram_wen), 32'h0);
    tick();
    Bus_wen = 1'b0;
    #1;
    check("sw_after_ro_write", Bus_rdata, 32'h0000F00F);

    // Buttons
    Bus_addr = 32'hFFFFF078;
    btn      = 5'h15;
    tick();
    tick();
    check("btn_read", Bus_rdata, 32'h00000015);

    // Reset mid-operation (LED nonzero) with a concurrent LED write
    cpu_rst   = 1'b1;
    Bus_addr  = 32'hFFFFF060;
    Bus_wen   = 1'b1;
    Bus_wdata = 32'h00123456;
    tick();
    cpu_rst = 1'b0;
    #1;
    check("rst2_led", 32'(led), 32'h0);

    // Display write right after reset, then observe the scan
    Bus_addr  = 32'hFFFFF000;
    Bus_wdata = 32'h76543210;
    tick();
    Bus_wen = 1'b0;
    #1;
    check("disp_read", Bus_rdata, 32'h76543210);
    check("scan_d0_en", 32'(dig_en), 32'hFE);
    check("scan_d0_seg", 32'(seg), 32'hC0);
    tick();
    tick();
    check("scan_hold_en", 32'(dig_en), 32'hFE);
    tick();
    check("scan_d1_en", 32'(dig_en), 32'hFD);
    check("scan_d1_seg", 32'(seg), 32'hF9);
    for (int d = 2; d <= 8; d++) begin
      repeat (4) tick();
      exp_en = ~(8'b1 << (d % 8));
      check($sformatf("scan_d%0d_en", d), 32'(dig_en), 32'(exp_en));
      check($sformatf("scan_d%0d_seg", d), 32'(seg), 32'(glyph[d % 8]));
    end

    // Timer
    Bus_addr  = 32'hFFFFF020;
    Bus_wdata = 32'hFFFFFFFE;
    Bus_wen   = 1'b1;
    tick();
    Bus_wen = 1'b0;
    #1;
`ifdef BRIDGE_TIMER_EN
    check("timer_load", Bus_rdata, 32'hFFFFFFFE);
    tick();
    tick();
    check("timer_hold", Bus_rdata, 32'hFFFFFFFE);
    tick();
    check("timer_inc", Bus_rdata, 32'hFFFFFFFF);
    repeat (3) tick();
    check("timer_wrap", Bus_rdata, 32'h00000000);
    tick();
    tick();
    Bus_wdata = 32'h00000100;
    Bus_wen   = 1'b1;
    tick();
    Bus_wen = 1'b0;
    #1;
    check("timer_write_wins", Bus_rdata, 32'h00000100);
    repeat (3) tick();
    check("timer_after_reload", Bus_rdata, 32'h00000101);
`else
    check("timer_absent", Bus_rdata, 32'h0);
    repeat (3) tick();
    check("timer_absent_later", Bus_rdata, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
